gray_rx_decoder: RTL
====================

// Module: gray_rx_decoder
// PURPOSE
//   Downstream consumer of the free-running gray_code counter. Samples the gray bus
//   (possibly from another clock domain) through a synchronizer chain and converts it
//   to binary. Classifies each change:
//     - legal single-bit step: reports the count direction.
//     - illegal multi-bit jump: pulses an error and keeps a saturating error count.
//   Sits between the gray-coded pointer/counter source and binary consumers
//   (FIFO level logic, debug counters).
// PARAMETERS
//   DATA_WIDTH     4  width of gray_in / bin_out
//   SYNC_STAGES    2  synchronizer flops on gray_in (legal range 2..4)
//   ERR_CNT_WIDTH  8  width of err_count (saturating)
// PORTS
//   clk        in   1              sole clock; all state on rising edge
//   reset      in   1              asynchronous, active-high reset
//   gray_in    in   DATA_WIDTH     gray-coded value from upstream counter
//   clear_err  in   1              sync clear of err_count (level, sampled each edge)
//   bin_out    out  DATA_WIDTH     binary equivalent of synchronized gray value
//   bin_valid  out  1              bin_out holds a real sample (low until flush done)
//   step_ok    out  1              1-cycle pulse: legal single-bit change
//   step_dir   out  1              with step_ok: 1 = up (+1 mod 2^W), 0 = down
//   step_err   out  1              1-cycle pulse: >1 bit changed between samples
//   err_count  out  ERR_CNT_WIDTH  number of step_err events, saturating
// BEHAVIOUR
//   Interface: one clock clk; reset is asynchronous and active-high.
//   Reset values: all outputs 0. Sync flops, prev_gray and flush counter are also 0.
//   State is INIT.
//   Synchronizer: gray_in -> SYNC_STAGES flops. s = last-stage output.
//   FSM INIT:
//     - counts SYNC_STAGES edges after reset release (flushes reset zeros).
//     - On the next edge: bin_out <= gray2bin(s), prev_gray <= s, bin_valid <= 1,
//       -> TRACK.
//     - No pulses are issued in INIT.
//   FSM TRACK (every edge):
//     - bin_out <= gray2bin(s); prev_gray <= s.
//     - d = popcount(s ^ prev_gray).
//     - d == 0: no pulse.
//     - d == 1: step_ok = 1; step_dir = (gray2bin(s) == gray2bin(prev_gray) + 1 mod 2^W).
//     - d > 1: step_err = 1; step_dir = 0; the new value is adopted as reference
//       (no resync state).
//   Pulses are registered and last exactly one cycle. step_dir is 0 whenever step_ok = 0.
//   Latency: a gray_in value stable before edge N appears on bin_out after edge
//   N + SYNC_STAGES. Its step_ok/step_err pulse is on the same cycle.
//   Wrap-around: binary max -> 0 (gray 1000 -> 0000 for W=4) is step_ok, dir = 1.
//   Binary 0 -> max is step_ok, dir = 0.
//   err_count:
//     - +1 per step_err, saturating at 2^ERR_CNT_WIDTH-1.
//     - clear_err alone -> 0.
//     - clear_err on the same edge as an error -> 1 (clear first, then count).
//   Reset mid-operation:
//     - immediate async return to reset values.
//     - re-enters INIT, so the first post-reset sample never flags a step.
// STRUCTURE
//   gray_pkg:
//     - functions gray2bin(), bin2gray(), popcount().
//     - typedef enum logic {INIT, TRACK} gray_rx_state_e.
//     - shared with the gray_code counter and its bench.
//   Sub-module gray_sync:
//     - parameterised DATA_WIDTH x SYNC_STAGES flop chain, async active-high reset.
//     - reusable for other CDC'd gray buses.
//   Top: FSM, flush counter, compare/convert stage, error counter.
// TESTING (DATA_WIDTH=4, SYNC_STAGES=2, ERR_CNT_WIDTH=8)
//   1. Reset 3 cycles, gray_in=0000 held -> all outputs 0 during reset;
//      bin_valid rises on 3rd edge after release; no pulses.
//   2. Drive gray_code sequence 0000,0001,0011,0010,0110 one per cycle ->
//      bin_out 0,1,2,3,4, each 2 edges after input; step_ok=1 / step_dir=1 on each change.
//   3. Up-wrap 1001->1000->0000 (bin 14,15,0) -> step_ok dir=1 twice; bin_out 15 then 0.
//      Reverse 0000->1000 -> step_ok dir=0, bin_out 15.
//   4. Jump 0001->0111 (2 bits) -> step_err 1 cycle, step_ok=0, err_count 0->1,
//      bin_out=5. Next 0101 is step_ok dir=1 (bin 6).
//   5. Force 260 illegal jumps -> err_count saturates at 255.
//      clear_err with no error -> 0. clear_err coincident with jump -> 1.
//   6. Assert reset mid-stream (bin_out=9) -> outputs 0 asynchronously.
//      After release: INIT flush, bin_valid after 3 edges, no step_err despite the
//      value change from pre-reset.

Source files
------------

// File: rtl/gray_pkg.sv
// Gray-code helpers and state type shared by the gray_code counter, this decoder and their benches.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic {INIT, TRACK} gray_rx_state_e;

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] popcount(input logic [GRAY_MAX_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// DATA_WIDTH x SYNC_STAGES flop chain for bringing a gray-coded bus into the clk domain.
module gray_sync #(
    parameter int DATA_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_rx_decoder.sv
// Synchronizes a gray-coded bus, converts it to binary and classifies each change as a
// legal up/down step or an illegal multi-bit jump with a saturating error count.
//   state | meaning
//   INIT  | flushing reset zeros out of the synchronizer, no pulses
//   TRACK | converting every sample and classifying changes
module gray_rx_decoder
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    gray_in,
    input  logic                     clear_err,
    output logic [DATA_WIDTH-1:0]    bin_out,
    output logic                     bin_valid,
    output logic                     step_ok,
    output logic                     step_dir,
    output logic                     step_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    gray_rx_state_e        state, state_nxt;
    logic [FLUSH_W-1:0]    flush_cnt, flush_nxt;
    logic [DATA_WIDTH-1:0] s, prev_gray, prev_nxt, bin_s, bin_prev, bin_nxt;
    logic                  valid_nxt, ok_nxt, dir_nxt, err_nxt;
    logic [ERR_CNT_WIDTH-1:0] cnt_nxt;
    logic [5:0]            diff;

    gray_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (gray_in),
        .q    (s)
    );

    assign bin_s    = DATA_WIDTH'(gray2bin(GRAY_MAX_W'(s)));
    assign bin_prev = DATA_WIDTH'(gray2bin(GRAY_MAX_W'(prev_gray)));
    assign diff     = popcount(GRAY_MAX_W'(s ^ prev_gray));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            flush_cnt <= '0;
            prev_gray <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_ok   <= 1'b0;
            step_dir  <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
            prev_gray <= prev_nxt;
            bin_out   <= bin_nxt;
            bin_valid <= valid_nxt;
            step_ok   <= ok_nxt;
            step_dir  <= dir_nxt;
            step_err  <= err_nxt;
            err_count <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        flush_nxt = flush_cnt;
        prev_nxt  = prev_gray;
        bin_nxt   = bin_out;
        valid_nxt = bin_valid;
        ok_nxt    = 1'b0;
        dir_nxt   = 1'b0;
        err_nxt   = 1'b0;
        // Clear takes effect before this edge's error is counted.
        cnt_nxt   = clear_err ? '0 : err_count;
        case (state)
            INIT: begin
                if (flush_cnt == FLUSH_W'(SYNC_STAGES)) begin
                    bin_nxt   = bin_s;
                    prev_nxt  = s;
                    valid_nxt = 1'b1;
                    state_nxt = TRACK;
                end else begin
                    flush_nxt = flush_cnt + FLUSH_W'(1);
                end
            end
            TRACK: begin
                bin_nxt  = bin_s;
                prev_nxt = s;
                if (diff == 6'd1) begin
                    ok_nxt  = 1'b1;
                    dir_nxt = (bin_s == bin_prev + DATA_WIDTH'(1));
                end else if (diff > 6'd1) begin
                    err_nxt = 1'b1;
                    if (cnt_nxt != '1) cnt_nxt = cnt_nxt + ERR_CNT_WIDTH'(1);
                end
            end
            default: state_nxt = INIT;
        endcase
    end

endmodule
